sba_interconnect: RTL and testbench
===================================

# sba_interconnect

Parametrised SBA (Simple Bus Architecture) interconnect between the OR32 CPU master and up to NUM_SLAVES slaves (ROM, BRAM, external bus, timer, …). It replaces the hand-written address/ack/data muxing in the SoC top with a registered single-outstanding-transaction bridge. The bridge decodes a region field and gates the strobe to exactly one slave. It adds a bus-error response for unmapped regions, an optional ack-timeout watchdog, and error capture registers.

## Interface
- NUM_SLAVES, 4: number of slave ports, 1..16.
- ADDR_W, 32: address width.
- DATA_W, 32: data width. Byte enables are DATA_W/8 bits.
- SEL_HI, 31: MSB of the region-select field.
- SEL_LO, 28: LSB of the region-select field.
- TIMEOUT, 255: maximum BUSY cycles waiting for a slave ack. Range 1..65535.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_m_addr  in  ADDR_W  master address. Held stable while i_m_stb is high.
- i_m_dat_w  in  DATA_W  master write data.
- i_m_we  in  DATA_W/8  byte write enables. All zero means read.
- i_m_stb  in  1  master request.
- o_m_ack  out  1  one-cycle completion pulse.
- o_m_dat_r  out  DATA_W  registered read data. Valid when o_m_ack is high.
- o_m_err  out  1  bus error, qualified by o_m_ack.
- o_s_addr, o_s_dat_w, o_s_we  out  ADDR_W/DATA_W/DATA_W/8  broadcast copies of the latched master request.
- o_s_stb  out  NUM_SLAVES  one-hot slave strobe.
- i_s_ack  in  NUM_SLAVES  slave acks.
- i_s_dat_r  in  NUM_SLAVES*DATA_W  flattened slave read data. Slave i occupies bits [i*DATA_W +: DATA_W].
- o_err_addr  out  ADDR_W  address of the most recent errored transaction.
- o_err_cnt  out  16  errored-transaction count. Saturates at 16'hFFFF.

## Operation
- Decode: slave index = i_m_addr[SEL_HI:SEL_LO]. Indexes >= NUM_SLAVES are unmapped.
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - On i_m_stb: latch addr, dat_w, we and the decoded index.
  - Mapped index: go to BUSY.
  - Unmapped index: go to DONE with err=1 and data=ERR_DATA (32'hDEAD_BEEF, truncated/replicated to DATA_W).
- **BUSY**
  - o_s_stb[idx]=1; all other strobes are 0.
  - When i_s_ack[idx] is high: capture i_s_dat_r slice idx into o_m_dat_r, err=0, go to DONE.
  - Acks on other slave bits are ignored.
- **DONE**
  - o_m_ack=1 for exactly one cycle, then go to IDLE.
  - Errored transaction: o_err_addr is loaded with the latched address and o_err_cnt increments (saturating).
- Outside BUSY, i_s_ack is ignored. This absorbs the trailing ack a slave produces after seeing its strobe during the ack cycle.
- Master rule: i_m_stb must be deasserted in the cycle after o_m_ack. A strobe still high in IDLE starts a new transaction.
- Slave rule: ack must fall within one cycle of strobe deassertion.
- Writes are not checked for region legality, e.g. writes to ROM are forwarded unchanged.

## Timing
- Reset values:
  - state IDLE.
  - o_m_ack, o_m_err, o_s_stb: 0.
  - o_m_dat_r, o_err_addr, o_err_cnt: 0.
  - o_s_addr, o_s_dat_w, o_s_we: 0.
- With a 1-cycle slave:
  - m_stb sampled at edge 0.
  - o_s_stb high in cycle 1.
  - Slave ack in cycle 2.
  - o_m_ack in cycle 3.
  - Master latency is 3 cycles.
- Unmapped address: o_m_ack with err in cycle 1, i.e. 1 cycle.
- Back-to-back requests: the minimum transaction period is latency + 1 cycle, because of the DONE→IDLE transition.
- o_s_stb is decoded combinationally from registered state and index, so it is glitch-free.
- o_s_addr, o_s_dat_w and o_s_we change only in IDLE on acceptance.
- Asynchronous reset mid-BUSY: the FSM drops to IDLE immediately, o_s_stb falls, and no ack is issued. Error capture registers are cleared.

## Configuration
- SBA_IC_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When the counter reaches TIMEOUT without an ack: go to DONE with err=1 and data=ERR_DATA, and drop the strobe.
  - If an ack and the timeout occur in the same cycle, the ack wins.
- SBA_IC_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely for the ack.
- Unmapped-region errors are present in both builds.

## Structure
- Package sba_pkg holds:
  - the state enum typedef (IDLE/BUSY/DONE);
  - ERR_DATA;
  - the default TIMEOUT.
- One sub-module, sba_addr_decode: purely combinational field extract producing index and mapped flag, parametrised by NUM_SLAVES, SEL_HI and SEL_LO.
- FSM, latches and error registers live in sba_interconnect.

## Test plan
- Read slave 1 at 32'h1000_0010, slave returns 32'h1234_5678 with a 1-cycle ack → o_s_stb=4'b0010 for one cycle; o_m_ack at cycle 3 with dat=32'h1234_5678, err=0.
- Write 32'hCAFE_F00D to 32'h2000_0004 with we=4'b0011 → o_s_we=4'b0011, o_s_dat_w matches, o_s_stb=4'b0100; ack; err=0.
- Access 32'h7000_0000 (NUM_SLAVES=4) → no o_s_stb; o_m_ack at cycle 1 with err=1, dat=32'hDEAD_BEEF; o_err_addr=32'h7000_0000; o_err_cnt=1.
- With SBA_IC_TIMEOUT_EN and TIMEOUT=8, slave 3 never acks → strobe drops and o_m_ack/o_m_err assert after 8 BUSY cycles. Without the macro, no ack within 1000 cycles.
- Trailing second ack from slave 0 in DONE, followed by an immediate request to slave 2 → the stray ack is ignored, and slave 2 data is returned correctly.
- Assert i_rst_n low during BUSY → o_s_stb=0 immediately, no o_m_ack, o_err_cnt=0. After release, a new read completes normally.

Source files
------------

// File: rtl/sba_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sba_pkg : shared state encoding and constants for the SBA interconnect   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sba_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] ERR_DATA        = 32'hDEAD_BEEF;
    localparam int          DEFAULT_TIMEOUT = 255;

endpackage
`default_nettype wire

// File: rtl/sba_addr_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sba_addr_decode : region-field extract giving slave index and mapped flag|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sba_addr_decode
    import sba_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int SEL_HI     = 31,
    parameter int SEL_LO     = 28,
    parameter int IDX_W      = 2
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output logic              mapped
);

    logic [31:0] w_field;
    logic        w_unused;

    assign w_field  = 32'(addr[SEL_HI:SEL_LO]);
    assign idx      = w_field[IDX_W-1:0];
    assign mapped   = (w_field < 32'(NUM_SLAVES));
    // Only the region field matters here; the rest of the address is sunk.
    assign w_unused = ^addr;

endmodule
`default_nettype wire

// File: rtl/sba_interconnect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sba_interconnect : single-outstanding SBA bridge, one master to N slaves |
// | Optional ack watchdog enabled by defining SBA_IC_TIMEOUT_EN.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sba_interconnect
    import sba_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SEL_HI     = 31,
    parameter int SEL_LO     = 28,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [ADDR_W-1:0]            i_m_addr,
    input  logic [DATA_W-1:0]            i_m_dat_w,
    input  logic [DATA_W/8-1:0]          i_m_we,
    input  logic                         i_m_stb,
    output logic                         o_m_ack,
    output logic [DATA_W-1:0]            o_m_dat_r,
    output logic                         o_m_err,
    output logic [ADDR_W-1:0]            o_s_addr,
    output logic [DATA_W-1:0]            o_s_dat_w,
    output logic [DATA_W/8-1:0]          o_s_we,
    output logic [NUM_SLAVES-1:0]        o_s_stb,
    input  logic [NUM_SLAVES-1:0]        i_s_ack,
    input  logic [NUM_SLAVES*DATA_W-1:0] i_s_dat_r,
    output logic [ADDR_W-1:0]            o_err_addr,
    output logic [15:0]                  o_err_cnt
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_dat_w;
    logic [BE_W-1:0]       r_we;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_W-1:0]     r_dat_r;
    logic                  r_err;
    logic [ADDR_W-1:0]     r_err_addr;
    logic [15:0]           r_err_cnt;

    logic [IDX_W-1:0]      w_dec_idx;
    logic                  w_dec_mapped;
    logic [NUM_SLAVES-1:0] w_sel;
    logic [DATA_W-1:0]     w_err_data;
    logic [DATA_W-1:0]     w_slave_rdata;
    logic                  w_busy;
    logic                  w_ack_hit;
    logic                  w_timeout;

    sba_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .SEL_HI     (SEL_HI),
        .SEL_LO     (SEL_LO),
        .IDX_W      (IDX_W)
    ) u_decode (
        .addr   (i_m_addr),
        .idx    (w_dec_idx),
        .mapped (w_dec_mapped)
    );

    for (genvar b = 0; b < DATA_W; b++) begin : g_err_bits
        assign w_err_data[b] = ERR_DATA[b % 32];
    end

    for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slave_sel
        assign w_sel[s] = (r_idx == IDX_W'(s));
    end

    always_comb begin
        w_slave_rdata = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            if (w_sel[s]) begin
                w_slave_rdata = w_slave_rdata | i_s_dat_r[s*DATA_W +: DATA_W];
            end
        end
    end

    assign w_busy    = (r_state == ST_BUSY);
    assign w_ack_hit = w_busy && |(i_s_ack & w_sel);

`ifdef SBA_IC_TIMEOUT_EN
    logic [15:0] r_tcnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tcnt <= '0;
        end else if (w_busy) begin
            r_tcnt <= r_tcnt + 16'd1;
        end else begin
            r_tcnt <= '0;
        end
    end

    // Fires on the TIMEOUT-th BUSY cycle; an ack in that same cycle takes priority.
    assign w_timeout = w_busy && (r_tcnt == 16'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_m_stb) begin
                    w_state_nxt = w_dec_mapped ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (w_ack_hit || w_timeout) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr     <= '0;
            r_dat_w    <= '0;
            r_we       <= '0;
            r_idx      <= '0;
            r_dat_r    <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
            r_err_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_m_stb) begin
                        r_addr  <= i_m_addr;
                        r_dat_w <= i_m_dat_w;
                        r_we    <= i_m_we;
                        r_idx   <= w_dec_idx;
                        r_err   <= !w_dec_mapped;
                        if (!w_dec_mapped) begin
                            r_dat_r <= w_err_data;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_ack_hit) begin
                        r_dat_r <= w_slave_rdata;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_dat_r <= w_err_data;
                        r_err   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (r_err) begin
                        r_err_addr <= r_addr;
                        if (r_err_cnt != 16'hFFFF) begin
                            r_err_cnt <= r_err_cnt + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_m_ack    = (r_state == ST_DONE);
    assign o_m_err    = r_err;
    assign o_m_dat_r  = r_dat_r;
    assign o_s_addr   = r_addr;
    assign o_s_dat_w  = r_dat_w;
    assign o_s_we     = r_we;
    assign o_s_stb    = w_busy ? w_sel : '0;
    assign o_err_addr = r_err_addr;
    assign o_err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sba_interconnect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sba_interconnect : directed self-checking bench for sba_interconnect  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sba_interconnect;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [AW-1:0]     m_addr = '0;
    logic [DW-1:0]     m_dat_w = '0;
    logic [DW/8-1:0]   m_we = '0;
    logic              m_stb = 1'b0;
    logic              m_ack;
    logic [DW-1:0]     m_dat_r;
    logic              m_err;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_dat_w;
    logic [DW/8-1:0]   s_we;
    logic [NS-1:0]     s_stb;
    logic [NS-1:0]     s_ack;
    logic [NS*DW-1:0]  s_dat_r;
    logic [AW-1:0]     err_addr;
    logic [15:0]       err_cnt;

    logic [DW-1:0]     s_data [NS];
    logic [NS-1:0]     ack_en = '1;

    int n_vec = 0;
    int n_miscompare = 0;

    always #5 clk = ~clk;

    sba_interconnect #(
        .NUM_SLAVES (NS),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .SEL_HI     (31),
        .SEL_LO     (28),
        .TIMEOUT    (TO)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_m_addr   (m_addr),
        .i_m_dat_w  (m_dat_w),
        .i_m_we     (m_we),
        .i_m_stb    (m_stb),
        .o_m_ack    (m_ack),
        .o_m_dat_r  (m_dat_r),
        .o_m_err    (m_err),
        .o_s_addr   (s_addr),
        .o_s_dat_w  (s_dat_w),
        .o_s_we     (s_we),
        .o_s_stb    (s_stb),
        .i_s_ack    (s_ack),
        .i_s_dat_r  (s_dat_r),
        .o_err_addr (err_addr),
        .o_err_cnt  (err_cnt)
    );

    // One-cycle slaves: ack follows strobe, so a trailing ack lands in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_ack <= '0;
        else        s_ack <= s_stb & ack_en;
    end

    always_comb begin
        s_dat_r = '0;
        for (int i = 0; i < NS; i++) s_dat_r[i*DW +: DW] = s_data[i];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscompare++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] we);
        m_addr  = a;
        m_dat_w = d;
        m_we    = we;
        m_stb   = 1'b1;
    endtask

    // Called #1 after a posedge; returns cycles until o_m_ack is seen.
    task automatic wait_ack(input int budget, output int lat, output logic got,
                            output logic [DW-1:0] dat, output logic err,
                            output logic [NS-1:0] mask, output int stb_cycles,
                            output logic [DW-1:0] sdw, output logic [3:0] swe,
                            output logic [AW-1:0] sad);
        lat = 0; got = 1'b0; dat = '0; err = 1'b0; mask = '0; stb_cycles = 0;
        sdw = '0; swe = '0; sad = '0;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            if (s_stb != '0) begin
                stb_cycles++;
                mask = mask | s_stb;
                sdw = s_dat_w; swe = s_we; sad = s_addr;
            end
            if (m_ack) begin
                lat = c; got = 1'b1; dat = m_dat_r; err = m_err;
                break;
            end
        end
        m_stb = 1'b0;
    endtask

    int              lat, stbc;
    logic            got, err;
    logic [DW-1:0]   dat, sdw;
    logic [3:0]      swe;
    logic [AW-1:0]   sad;
    logic [NS-1:0]   mask;

    initial begin
        s_data[0] = 32'hA0A0_0000;
        s_data[1] = 32'h1234_5678;
        s_data[2] = 32'h0BAD_0002;
        s_data[3] = 32'h3333_3333;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, m_ack}, 32'd0);
        check("rst_stb", {28'd0, s_stb}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_err", {31'd0, m_err}, 32'd0);
        check("rst_dat_r", m_dat_r, 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        check("rst_s_addr", s_addr, 32'd0);
        check("rst_s_dat_w", s_dat_w, 32'd0);
        check("rst_s_we", {28'd0, s_we}, 32'd0);

        // Read slave 1
        start(32'h1000_0010, 32'd0, 4'b0000);
        wait_ack(50, lat, got, dat, err, mask, stbc, sdw, swe, sad);
        check("rd1_got", {31'd0, got}, 32'd1);
        check("rd1_lat", lat, 32'd3);
        check("rd1_mask", {28'd0, mask}, 32'h2);
        check("rd1_dat", dat, 32'h1234_5678);
        check("rd1_err", {31'd0, err}, 32'd0);
        check("rd1_s_addr", sad, 32'h1000_0010);

        // Write slave 2
        @(posedge clk); #1;
        start(32'h2000_0004, 32'hCAFE_F00D, 4'b0011);
        wait_ack(50, lat, got, dat, err, mask, stbc, sdw, swe, sad);
        check("wr2_lat", lat, 32'd3);
        check("wr2_mask", {28'd0, mask}, 32'h4);
        check("wr2_we", {28'd0, swe}, 32'h3);
        check("wr2_dat_w", sdw, 32'hCAFE_F00D);
        check("wr2_err", {31'd0, err}, 32'd0);

        // Unmapped region 7
        @(posedge clk); #1;
        start(32'h7000_0000, 32'd0, 4'b0000);
        wait_ack(50, lat, got, dat, err, mask, stbc, sdw, swe, sad);
        check("um7_lat", lat, 32'd1);
        check("um7_mask", {28'd0, mask}, 32'd0);
        check("um7_err", {31'd0, err}, 32'd1);
        check("um7_dat", dat, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        check("um7_err_addr", err_addr, 32'h7000_0000);
        check("um7_err_cnt", {16'd0, err_cnt}, 32'd1);

        // First unmapped index (== NUM_SLAVES)
        start(32'h4000_0008, 32'd0, 4'b0000);
        wait_ack(50, lat, got, dat, err, mask, stbc, sdw, swe, sad);
        check("um4_err", {31'd0, err}, 32'd1);
        @(posedge clk); #1;
        check("um4_err_addr", err_addr, 32'h4000_0008);
        check("um4_err_cnt", {16'd0, err_cnt}, 32'd2);

        // Slave 0 read, then immediate request to slave 2 while slave 0 trails its ack
        s_data[2] = 32'h5A5A_0002;
        start(32'h0000_0000, 32'd0, 4'b0000);
        wait_ack(50, lat, got, dat, err, mask, stbc, sdw, swe, sad);
        check("s0_dat", dat, 32'hA0A0_0000);
        start(32'h2000_0020, 32'd0, 4'b0000);
        wait_ack(50, lat, got, dat, err, mask, stbc, sdw, swe, sad);
        check("b2b_lat", lat, 32'd4);
        check("b2b_mask", {28'd0, mask}, 32'h4);
        check("b2b_dat", dat, 32'h5A5A_0002);
        check("b2b_err", {31'd0, err}, 32'd0);
        check("b2b_err_cnt", {16'd0, err_cnt}, 32'd2);

        // Slave 3 never acks
        ack_en[3] = 1'b0;
        @(posedge clk); #1;
        start(32'h3000_0000, 32'd0, 4'b0000);
`ifdef SBA_IC_TIMEOUT_EN
        wait_ack(50, lat, got, dat, err, mask, stbc, sdw, swe, sad);
        check("to_lat", lat, TO + 1);
        check("to_stb_cycles", stbc, TO);
        check("to_err", {31'd0, err}, 32'd1);
        check("to_dat", dat, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        check("to_err_cnt", {16'd0, err_cnt}, 32'd3);
        start(32'h3000_0000, 32'd0, 4'b0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_stb = 1'b0;
`else
        wait_ack(1000, lat, got, dat, err, mask, stbc, sdw, swe, sad);
        check("noto_got", {31'd0, got}, 32'd0);
`endif
        check("busy_stb", {28'd0, s_stb}, 32'h8);

        // Asynchronous reset mid-BUSY
        #2 rst_n = 1'b0;
        #1;
        check("arst_stb", {28'd0, s_stb}, 32'd0);
        check("arst_ack", {31'd0, m_ack}, 32'd0);
        check("arst_err_cnt", {16'd0, err_cnt}, 32'd0);
        check("arst_err_addr", err_addr, 32'd0);
        ack_en[3] = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ack", {31'd0, m_ack}, 32'd0);

        s_data[1] = 32'h0F0F_1111;
        start(32'h1000_0040, 32'd0, 4'b0000);
        wait_ack(50, lat, got, dat, err, mask, stbc, sdw, swe, sad);
        check("post_lat", lat, 32'd3);
        check("post_dat", dat, 32'h0F0F_1111);
        check("post_err", {31'd0, err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
`default_nettype wire
